// File: rtl/bus_if_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : bus_if_wbuf
// Purpose  : CPU-side memory interface between the MEM stage, the SPM and the
//            shared bus arbiter. Bus writes are posted into a small FIFO and
//            drained in order ahead of any bus read. A bus access stuck in
//            ACCESS too long is aborted and flagged on bus_err.
// Revision : 1.0 - initial release
// ============================================================================
module bus_if_wbuf #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int IDX_MSB    = 29,
    parameter int IDX_LSB    = 27,
    parameter int SPM_INDEX  = 1,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_err,
    output logic              wbuf_empty,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data
);

    localparam int c_PTR_W = $clog2(WBUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = IDX_MSB - IDX_LSB + 1;
    localparam int c_TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REQ    = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_STALL  = 2'd3;

    localparam logic c_READ  = 1'b1;
    localparam logic c_WRITE = 1'b0;

    logic [1:0]        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic              eng_rd_q, eng_rd_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];

    logic w_req, w_local, w_bus_rd_req, w_bus_wr_req;
    logic w_full, w_push, w_pop;
    logic w_rd_active, w_timeout, w_acc_done, w_abort, w_rd_done;

    assign w_req        = ~flush & ~as_;
    assign w_local      = w_req & (addr[IDX_MSB:IDX_LSB] == c_IDX_W'(SPM_INDEX));
    assign w_bus_rd_req = w_req & ~w_local & (rw == c_READ);
    assign w_bus_wr_req = w_req & ~w_local & (rw == c_WRITE);

    // Full is taken from the registered count so a same-cycle pop never frees a slot.
    assign w_full = (cnt_q == c_CNT_W'(WBUF_DEPTH));
    assign w_push = w_bus_wr_req & ~w_full & ~stall;

    // Any non-IDLE state with a read loaded keeps the SPM port off the CPU path.
    assign w_rd_active = eng_rd_q & (state_q != c_ST_IDLE);
    assign w_timeout   = (TIMEOUT != 0) && (to_cnt_q == c_TO_W'(TIMEOUT));
    assign w_acc_done  = (state_q == c_ST_ACCESS) & (~bus_rdy_ | w_timeout);
    assign w_abort     = (state_q == c_ST_ACCESS) & bus_rdy_ & w_timeout;
    assign w_rd_done   = w_acc_done & eng_rd_q;
    assign w_pop       = w_acc_done & ~eng_rd_q;

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign bus_err     = bus_err_q;
    assign wbuf_empty  = (cnt_q == '0) & ~((state_q != c_ST_IDLE) & ~eng_rd_q);

    // CPU-facing combinational outputs: SPM routing, read data mux and stall request.
    always_comb begin
        rd_data = '0;
        spm_as_ = 1'b1;
        busy    = (w_bus_wr_req & w_full)
                | (w_bus_rd_req & ~w_rd_done & (state_q != c_ST_STALL));
        if (w_local & ~stall & ~w_rd_active) begin
            spm_as_ = 1'b0;
            if (rw == c_READ) begin
                rd_data = spm_rd_data;
            end
        end
        if (state_q == c_ST_STALL) begin
            rd_data = rd_buf_q;
        end else if (w_rd_done & ~w_abort & ~flush) begin
            rd_data = bus_rd_data;
        end
    end

    // Bus engine and write-buffer bookkeeping; buffered writes always go out before a read.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_err_d     = 1'b0;
        rd_buf_d      = rd_buf_q;
        to_cnt_d      = to_cnt_q;
        eng_rd_d      = eng_rd_q;
        wr_ptr_d      = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            c_ST_IDLE: begin
                if (cnt_q != '0) begin
                    bus_addr_d    = wb_addr_q[rd_ptr_q];
                    bus_wr_data_d = wb_data_q[rd_ptr_q];
                    bus_rw_d      = c_WRITE;
                    bus_req_d     = 1'b0;
                    eng_rd_d      = 1'b0;
                    state_d       = c_ST_REQ;
                end else if (w_bus_rd_req) begin
                    bus_addr_d    = addr;
                    bus_wr_data_d = '0;
                    bus_rw_d      = c_READ;
                    bus_req_d     = 1'b0;
                    eng_rd_d      = 1'b1;
                    state_d       = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (~bus_grnt_) begin
                    bus_as_d = 1'b0;
                    state_d  = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                bus_as_d = 1'b1;
                if (w_acc_done) begin
                    bus_req_d     = 1'b1;
                    bus_addr_d    = '0;
                    bus_wr_data_d = '0;
                    bus_rw_d      = c_READ;
                    to_cnt_d      = '0;
                    bus_err_d     = w_abort;
                    if (eng_rd_q) begin
                        rd_buf_d = w_abort ? '0 : bus_rd_data;
                        // A flushed read must not resurface through the STALL path.
                        state_d  = (stall & ~flush) ? c_ST_STALL : c_ST_IDLE;
                    end else begin
                        state_d  = c_ST_IDLE;
                    end
                end else if (bus_rdy_) begin
                    to_cnt_d = to_cnt_q + c_TO_W'(1);
                end
            end
            default: begin
                if (~stall) begin
                    state_d = c_ST_IDLE;
                end
            end
        endcase
    end

    // Control and bus-master registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= c_ST_IDLE;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_rw_q      <= c_READ;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_err_q     <= 1'b0;
            rd_buf_q      <= '0;
            to_cnt_q      <= '0;
            eng_rd_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_err_q     <= bus_err_d;
            rd_buf_q      <= rd_buf_d;
            to_cnt_q      <= to_cnt_d;
            eng_rd_q      <= eng_rd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    // Write-buffer storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (w_push & ~reset) begin
            wb_addr_q[wr_ptr_q] <= addr;
            wb_data_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire
